// File: rtl/wb_cmd_pkg.sv
// Shared encodings for the Wishbone command initiator and its lane-alignment helper.
package wb_cmd_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BUSERR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_MISALIGN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_cmd_initiator_lane_align.sv
// Byte-lane steering for 32-bit Wishbone: select mask, write-data replication,
// alignment check and right-justified, zero-extended read-data extraction.
module wb_lane_align
  import wb_cmd_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdt_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdt_i >> {addr_lo_i, 3'b000};
    sel_o      = 4'b0000;
    wdat_o     = 32'd0;
    misalign_o = 1'b0;
    rdata_o    = 32'd0;
    case (size_i)
      SZ_BYTE: begin
        sel_o   = 4'b0001 << addr_lo_i;
        wdat_o  = {4{wdata_i[7:0]}};
        rdata_o = {24'd0, shifted[7:0]};
      end
      SZ_HALF: begin
        sel_o      = 4'b0011 << addr_lo_i;
        wdat_o     = {2{wdata_i[15:0]}};
        rdata_o    = {16'd0, shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        sel_o      = 4'b1111;
        wdat_o     = wdata_i;
        rdata_o    = shifted;
        misalign_o = |addr_lo_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Single-transfer Wishbone classic initiator: command in, one bus cycle with
// timeout, response (data + status) out over a valid/ready channel.
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [1:0]            i_cmd_size,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_status,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [31:0]           o_wb_dat,
  output logic [3:0]            o_wb_sel,
  output logic                  o_wb_we,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  input  logic [31:0]           i_wb_rdt,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  output logic                  o_busy
);

  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            status_q, status_d;

  logic        idle, bus;
  logic [1:0]  al_size, al_addr;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat, al_rdata;
  logic        al_misalign;

  assign idle = (state_q == S_IDLE);
  assign bus  = (state_q == S_BUS);

  // While idle the aligner checks the incoming command; afterwards it serves the latched one.
  assign al_size = idle ? i_cmd_size      : size_q;
  assign al_addr = idle ? i_cmd_addr[1:0] : addr_q[1:0];

  wb_lane_align u_align (
    .size_i     (al_size),
    .addr_lo_i  (al_addr),
    .wdata_i    (wdata_q),
    .rdt_i      (i_wb_rdt),
    .sel_o      (al_sel),
    .wdat_o     (al_wdat),
    .misalign_o (al_misalign),
    .rdata_o    (al_rdata)
  );

  assign o_cmd_ready  = idle;
  assign o_busy       = !idle;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_rsp_rdata  = rdata_q;
  assign o_rsp_status = status_q;
  assign o_wb_cyc     = bus;
  assign o_wb_stb     = bus;
  assign o_wb_we      = bus & we_q;
  assign o_wb_adr     = bus ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign o_wb_dat     = bus ? al_wdat : 32'd0;
  assign o_wb_sel     = bus ? al_sel  : 4'b0000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      cnt_q    <= 16'd0;
      rdata_q  <= 32'd0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          we_d    = i_cmd_we;
          size_d  = i_cmd_size;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          cnt_d   = TIMEOUT_LD;
          if (al_misalign) begin
            status_d = ST_MISALIGN;
            rdata_d  = 32'd0;
            state_d  = S_RESP;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // ack wins over err, and both win over an expiring counter in the same cycle.
        if (i_wb_ack) begin
          status_d = ST_OK;
          rdata_d  = we_q ? 32'd0 : al_rdata;
          state_d  = S_RESP;
        end else if (i_wb_err) begin
          status_d = ST_BUSERR;
          rdata_d  = 32'd0;
          state_d  = S_RESP;
        end else if (cnt_q == 16'd0) begin
          status_d = ST_TIMEOUT;
          rdata_d  = 32'd0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with a syscon-like responder and a byte-level reference model.
module tb_wb_cmd_initiator;

  localparam int AW = 32;
  localparam int TO = 4;
  localparam logic [31:0] INIT0 = 32'h80FFFFFF;
  localparam logic [31:0] INIT1 = 32'hDEADBEEF;
  localparam logic [31:0] INIT2 = 32'h12345678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [1:0]    i_cmd_size;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_wdata;
  logic          o_rsp_valid, i_rsp_ready;
  logic [31:0]   o_rsp_rdata;
  logic [1:0]    o_rsp_status;
  logic [AW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat, wb_rdt;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we, o_wb_cyc, o_wb_stb, wb_ack, wb_err, o_busy;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_size(i_cmd_size), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_status(o_rsp_status),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(wb_rdt),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_busy(o_busy)
  );

  // Responder: mode 0 acks one cycle after cyc, mode 1 never answers, mode 2 errs at once.
  int          mode = 0;
  logic        late_ack = 1'b0;
  logic        ack_q;
  logic [31:0] rdt_q;
  logic [31:0] mem [0:15] = '{0: INIT0, 1: INIT1, 2: INIT2, default: 32'h0};

  assign wb_ack = ack_q | late_ack;
  assign wb_err = (mode == 2) && o_wb_cyc && o_wb_stb;
  assign wb_rdt = rdt_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      rdt_q <= 32'd0;
    end else begin
      ack_q <= (mode == 0) && o_wb_cyc && o_wb_stb && !ack_q;
      if ((mode == 0) && o_wb_cyc && o_wb_stb && !ack_q) begin
        rdt_q <= mem[o_wb_adr[5:2]];
        if (o_wb_we)
          for (int b = 0; b < 4; b++)
            if (o_wb_sel[b]) mem[o_wb_adr[5:2]][8*b +: 8] <= o_wb_dat[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [7:0]  mdl [0:63];
  bit          exp_active, exp_bus;
  logic [31:0] exp_adr, exp_dat, exp_rdata;
  logic [3:0]  exp_sel;
  logic        exp_we;
  logic [1:0]  exp_status;

  int          n_checks = 0, n_errors = 0;
  int          cyc_cnt;
  logic [3:0]  last_sel;
  logic [31:0] last_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    if (!exp_active) begin
      chk("idle_cmd_ready", 32'(o_cmd_ready), 1);
      chk("idle_cyc", 32'(o_wb_cyc), 0);
      chk("idle_rsp_valid", 32'(o_rsp_valid), 0);
      chk("idle_busy", 32'(o_busy), 0);
    end else begin
      chk("active_cmd_ready", 32'(o_cmd_ready), 0);
      chk("active_busy", 32'(o_busy), 1);
      if (o_wb_cyc) begin
        if (!exp_bus) chk("cyc_without_bus", 32'(o_wb_cyc), 0);
        chk("wb_stb", 32'(o_wb_stb), 1);
        chk("wb_adr", o_wb_adr, exp_adr);
        chk("wb_sel", 32'(o_wb_sel), 32'(exp_sel));
        chk("wb_dat", o_wb_dat, exp_dat);
        chk("wb_we", 32'(o_wb_we), 32'(exp_we));
      end
      if (o_rsp_valid) begin
        chk("rsp_rdata", o_rsp_rdata, exp_rdata);
        chk("rsp_status", 32'(o_rsp_status), 32'(exp_status));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (o_wb_cyc) begin
      cyc_cnt++;
      last_sel = o_wb_sel;
      last_dat = o_wb_dat;
    end
    compare();
  endtask

  // Expected outcome from little-endian byte memory and lane rules.
  task automatic model_cmd(input logic we, input logic [1:0] size, input int addr,
                           input logic [31:0] wdata);
    int n;
    bit mis;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    mis = (n == 0) || ((addr % n) != 0);
    exp_bus = !mis;
    exp_we = we;
    exp_adr = 32'(addr - (addr % 4));
    exp_sel = 4'b0000;
    exp_dat = 32'd0;
    exp_rdata = 32'd0;
    if (!mis) begin
      for (int i = 0; i < n; i++) exp_sel[(addr % 4) + i] = 1'b1;
      for (int k = 0; k < 4; k++) exp_dat[8*k +: 8] = wdata[8*(k % n) +: 8];
    end
    if (mis) exp_status = 2'b11;
    else if (mode == 1) exp_status = 2'b10;
    else if (mode == 2) exp_status = 2'b01;
    else begin
      exp_status = 2'b00;
      for (int i = 0; i < n; i++)
        if (we) mdl[addr + i] = wdata[8*i +: 8];
        else exp_rdata[8*i +: 8] = mdl[addr + i];
    end
  endtask

  task automatic send_cmd(input logic we, input logic [1:0] size, input int addr,
                          input logic [31:0] wdata);
    bit accepted = 0;
    model_cmd(we, size, addr, wdata);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_size  = size;
    i_cmd_addr  = 32'(addr);
    i_cmd_wdata = wdata;
    cyc_cnt     = 0;
    last_sel    = 4'b0000;
    last_dat    = 32'd0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (o_cmd_ready) begin
        exp_active = 1'b1;
        accepted = 1;
      end
      step();
    end
    i_cmd_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept: got no handshake required handshake within 20 cycles");
    end
  endtask

  task automatic get_rsp(input int hold, output int lat, output logic [31:0] rd,
                         output logic [1:0] st);
    bit done = 0;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    rd = o_rsp_rdata;
    st = o_rsp_status;
    if (!o_rsp_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_wait: got no rsp_valid required rsp_valid within 40 cycles");
      return;
    end
    i_rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_rsp_valid", 32'(o_rsp_valid), 1);
    end
    i_rsp_ready = 1'b1;
    for (int t = 0; t < 5 && !done; t++) begin
      if (o_rsp_valid) begin
        exp_active = 1'b0;
        done = 1;
      end
      step();
    end
    i_rsp_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic [1:0]  st;

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_size = 2'd0;
    i_cmd_addr = '0; i_cmd_wdata = 32'd0; i_rsp_ready = 1'b0;
    exp_active = 1'b0; exp_bus = 1'b0;
    for (int a = 0; a < 64; a++) mdl[a] = 8'h00;
    for (int b = 0; b < 4; b++) begin
      mdl[b]     = INIT0[8*b +: 8];
      mdl[4 + b] = INIT1[8*b +: 8];
      mdl[8 + b] = INIT2[8*b +: 8];
    end

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc", 32'(o_wb_cyc), 0);
    chk("rst_stb", 32'(o_wb_stb), 0);
    chk("rst_we", 32'(o_wb_we), 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_dat", o_wb_dat, 0);
    chk("rst_sel", 32'(o_wb_sel), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    chk("rst_status", 32'(o_rsp_status), 0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Word read of the version register
    send_cmd(1'b0, 2'd2, 'h00, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("word_rd_latency", 32'(lat), 3);
    chk("word_rd_sel", 32'(last_sel), 32'hF);
    chk("word_rd_data", rd, 32'h80FFFFFF);
    chk("word_rd_status", 32'(st), 0);

    // Byte write to nmi_vec byte 0 and readback
    send_cmd(1'b1, 2'd0, 'h0C, 32'h000000A5);
    get_rsp(0, lat, rd, st);
    chk("byte_wr_sel", 32'(last_sel), 32'h1);
    chk("byte_wr_dat", last_dat, 32'hA5A5A5A5);
    chk("byte_wr_rdata", rd, 0);
    chk("byte_wr_status", 32'(st), 0);
    send_cmd(1'b0, 2'd2, 'h0C, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("byte_wr_readback", rd, 32'h000000A5);

    // Half reads, aligned and misaligned
    send_cmd(1'b0, 2'd1, 'h0A, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("half_rd_sel", 32'(last_sel), 32'hC);
    chk("half_rd_data", rd, 32'h00001234);
    send_cmd(1'b0, 2'd1, 'h09, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("half_mis_cyc", 32'(cyc_cnt), 0);
    chk("half_mis_status", 32'(st), 3);
    chk("half_mis_rdata", rd, 0);
    chk("half_mis_latency", 32'(lat), 1);

    // Top byte lane, illegal size, misaligned word
    send_cmd(1'b0, 2'd0, 'h07, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("byte_rd_lane3", rd, 32'h000000DE);
    send_cmd(1'b0, 2'd3, 'h04, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("size3_status", 32'(st), 3);
    send_cmd(1'b0, 2'd2, 'h02, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("word_mis_status", 32'(st), 3);

    // Timeout, then a stray late ack, then a normal read
    mode = 1;
    send_cmd(1'b0, 2'd2, 'h00, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("timeout_cyc_cycles", 32'(cyc_cnt), 5);
    chk("timeout_status", 32'(st), 2);
    chk("timeout_rdata", rd, 0);
    late_ack = 1'b1;
    step();
    late_ack = 1'b0;
    step();
    mode = 0;
    send_cmd(1'b0, 2'd2, 'h04, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("after_timeout_data", rd, 32'hDEADBEEF);
    chk("after_timeout_status", 32'(st), 0);

    // Bus error with a stalled response consumer
    mode = 2;
    send_cmd(1'b1, 2'd2, 'h10, 32'h11223344);
    get_rsp(10, lat, rd, st);
    chk("err_status", 32'(st), 1);
    chk("err_rdata", rd, 0);
    chk("err_latency", 32'(lat), 2);
    mode = 0;
    send_cmd(1'b0, 2'd2, 'h10, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("err_no_write", rd, 0);

    // Reset in the middle of a bus cycle
    mode = 1;
    send_cmd(1'b0, 2'd2, 'h00, 32'd0);
    step();
    chk("pre_rst_cyc", 32'(o_wb_cyc), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(o_wb_cyc), 0);
    chk("mid_rst_stb", 32'(o_wb_stb), 0);
    chk("mid_rst_rsp_valid", 32'(o_rsp_valid), 0);
    exp_active = 1'b0;
    step();
    rst_n = 1'b1;
    chk("post_rst_cmd_ready", 32'(o_cmd_ready), 1);
    step();
    step();
    mode = 0;
    send_cmd(1'b0, 2'd2, 'h00, 32'd0);
    get_rsp(0, lat, rd, st);
    chk("post_rst_data", rd, 32'h80FFFFFF);
    chk("post_rst_status", 32'(st), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
